// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one request/grant/response memory bus.
// Optional response watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_adr_i,
   output logic [31:0]     if_rdata_o,
   output logic            if_ack_o,
   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic [XLEN-1:0] d_adr_i,
   input  logic [XLEN-1:0] d_wdata_i,
   input  logic [2:0]      d_size_i,
   output logic [XLEN-1:0] d_rdata_o,
   output logic            d_ack_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_adr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [2:0]      mem_size_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic            stall_o,
   output logic            err_o
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t state;
   logic   owner_d;
   logic   if_pend_c;
   logic   d_pend_c;

   // A request raised in the same cycle as its own ack is already served.
   assign if_pend_c = if_req_i & ~if_ack_o;
   assign d_pend_c  = d_req_i & ~d_ack_o;
   assign stall_o   = if_pend_c | d_pend_c;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt;
   logic             timeout_c;
   assign timeout_c = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_cfg;
   assign unused_cfg = ^32'(TIMEOUT_CYCLES);
   assign err_o      = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         owner_d     <= 1'b0;
         if_rdata_o  <= '0;
         if_ack_o    <= 1'b0;
         d_rdata_o   <= '0;
         d_ack_o     <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_adr_o   <= '0;
         mem_wdata_o <= '0;
         mem_size_o  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt         <= '0;
         err_o       <= 1'b0;
`endif
      end else begin
         if_ack_o <= 1'b0;
         d_ack_o  <= 1'b0;
         case (state)
            IDLE: begin
               // Data wins: exe is the older stage and must drain first.
               if (d_pend_c) begin
                  owner_d     <= 1'b1;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= d_we_i;
                  mem_adr_o   <= d_adr_i;
                  mem_wdata_o <= d_wdata_i;
                  mem_size_o  <= d_size_i;
                  state       <= REQ;
               end else if (if_pend_c) begin
                  owner_d     <= 1'b0;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b0;
                  mem_adr_o   <= if_adr_i;
                  mem_wdata_o <= '0;
                  mem_size_o  <= 3'b010;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (mem_gnt_i) begin
                  mem_req_o <= 1'b0;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (mem_rvalid_i) begin
                  if (owner_d) begin
                     d_rdata_o <= mem_rdata_i;
                     d_ack_o   <= 1'b1;
                  end else begin
                     if_rdata_o <= mem_rdata_i[31:0];
                     if_ack_o   <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
`ifdef MEM_ARB_TIMEOUT_EN
         cnt <= (state == IDLE) ? '0 : cnt + CNT_W'(1);
         // Watchdog completes the owner's access with zero data and latches the error.
         if (timeout_c) begin
            if (owner_d) begin
               d_rdata_o <= '0;
               d_ack_o   <= 1'b1;
            end else begin
               if_rdata_o <= '0;
               if_ack_o   <= 1'b1;
            end
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
            state     <= IDLE;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: load, store/fetch contention, grant stall, held fetch,
// response watchdog (either build of MEM_ARB_TIMEOUT_EN) and reset in the response phase.
module tb_mem_arbiter;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            if_req, if_ack, d_req, d_we, d_ack;
   logic [XLEN-1:0] if_adr, d_adr, d_wdata, d_rdata;
   logic [31:0]     if_rdata;
   logic [2:0]      d_size, mem_size;
   logic            mem_req, mem_we, mem_gnt, mem_rvalid, stall, err;
   logic [XLEN-1:0] mem_adr, mem_wdata, mem_rdata;

   int n_vec = 0;
   int n_err = 0;

   mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req_i(if_req), .if_adr_i(if_adr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
      .d_req_i(d_req), .d_we_i(d_we), .d_adr_i(d_adr), .d_wdata_i(d_wdata),
      .d_size_i(d_size), .d_rdata_o(d_rdata), .d_ack_o(d_ack),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_adr_o(mem_adr),
      .mem_wdata_o(mem_wdata), .mem_size_o(mem_size),
      .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .stall_o(stall), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Move to the next cycle; registered outputs are settled 2 ns after the edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " mem_req"}, 64'(mem_req), 64'd0);
      check({tag, " mem_adr"}, 64'(mem_adr), 64'd0);
      check({tag, " mem_we"}, 64'(mem_we), 64'd0);
      check({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
      check({tag, " mem_size"}, 64'(mem_size), 64'd0);
      check({tag, " acks"}, 64'({if_ack, d_ack}), 64'd0);
      check({tag, " rdata"}, 64'({if_rdata, d_rdata}), 64'd0);
      check({tag, " err"}, 64'(err), 64'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      {if_req, d_req, d_we, mem_gnt, mem_rvalid} = '0;
      {if_adr, d_adr, d_wdata, mem_rdata} = '0;
      d_size = 3'b010;
      repeat (3) step();
      check_idle_outputs("reset");
      reset_n = 1'b1;
      step();

      // Single load at 0x100.
      d_req = 1'b1; d_adr = 32'h100; d_we = 1'b0;
      #1 check("load stall t0", 64'(stall), 64'd1);
      step();
      check("load req t1", 64'(mem_req), 64'd1);
      check("load adr t1", 64'(mem_adr), 64'h100);
      check("load we t1", 64'(mem_we), 64'd0);
      mem_gnt = 1'b1;
      step();
      check("load req t2", 64'(mem_req), 64'd0);
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      step();
      check("load ack t3", 64'(d_ack), 64'd1);
      check("load rdata t3", 64'(d_rdata), 64'hDEADBEEF);
      check("load we t3", 64'(mem_we), 64'd0);
      mem_rvalid = 1'b0; d_req = 1'b0;
      step();
      check("load ack t4", 64'(d_ack), 64'd0);
      check("load no reissue", 64'(mem_req), 64'd0);

      // Store and fetch together: store first, then fetch; fetch held afterwards.
      if_req = 1'b1; if_adr = 32'h300;
      d_req = 1'b1; d_we = 1'b1; d_adr = 32'h200; d_wdata = 32'h55;
      step();
      check("st req", 64'(mem_req), 64'd1);
      check("st we", 64'(mem_we), 64'd1);
      check("st adr", 64'(mem_adr), 64'h200);
      check("st wdata", 64'(mem_wdata), 64'h55);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
      step();
      check("st ack", 64'(d_ack), 64'd1);
      check("st no if ack", 64'(if_ack), 64'd0);
      mem_rvalid = 1'b0; d_req = 1'b0; d_we = 1'b0;
      #1 check("st stall at ack", 64'(stall), 64'd1);
      step();
      check("if req", 64'(mem_req), 64'd1);
      check("if we", 64'(mem_we), 64'd0);
      check("if adr", 64'(mem_adr), 64'h300);
      check("if wdata", 64'(mem_wdata), 64'd0);
      check("if size", 64'(mem_size), 64'd2);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      check("if stall resp", 64'(stall), 64'd1);
      step();
      mem_rvalid = 1'b0;
      check("if ack", 64'(if_ack), 64'd1);
      check("if rdata", 64'(if_rdata), 64'h12345678);
      check("if stall at ack", 64'(stall), 64'd0);
      if_adr = 32'h304;
      step();
      check("held no dup req", 64'(mem_req), 64'd0);
      check("held stall", 64'(stall), 64'd1);
      step();
      check("held next req", 64'(mem_req), 64'd1);
      check("held next adr", 64'(mem_adr), 64'h304);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD;
      step();
      mem_rvalid = 1'b0;
      check("held ack", 64'(if_ack), 64'd1);
      check("held rdata", 64'(if_rdata), 64'h0BAD0BAD);
      if_req = 1'b0;
      step();

      // Grant withheld 5 cycles, stray rvalid in REQ ignored.
      d_req = 1'b1; d_adr = 32'h400; d_size = 3'b001;
      for (int i = 1; i <= 6; i++) begin
         step();
         check("gs req", 64'(mem_req), 64'd1);
         check("gs adr", 64'(mem_adr), 64'h400);
         check("gs size", 64'(mem_size), 64'd1);
         mem_rvalid = (i == 2);
         mem_rdata  = 32'hFFFF_FFFF;
         mem_gnt    = (i == 6);
      end
      step();
      check("gs ack early", 64'(d_ack), 64'd0);
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A50001;
      step();
      mem_rvalid = 1'b0;
      check("gs ack", 64'(d_ack), 64'd1);
      check("gs rdata", 64'(d_rdata), 64'hA5A50001);
      d_req = 1'b0; d_size = 3'b010;
      step();

      // No response: watchdog completes after 16 cycles when enabled.
      d_req = 1'b1; d_adr = 32'h600;
      step();
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      for (int t = 2; t <= 16; t++) begin
         check("to no ack", 64'(d_ack), 64'd0);
         step();
      end
`ifdef MEM_ARB_TIMEOUT_EN
      check("to ack", 64'(d_ack), 64'd1);
      check("to rdata", 64'(d_rdata), 64'd0);
      check("to err", 64'(err), 64'd1);
      d_req = 1'b0;
      repeat (3) step();
      check("to err sticky", 64'(err), 64'd1);
      check("to req dropped", 64'(mem_req), 64'd0);
`else
      for (int t = 0; t < 20; t++) begin
         check("to wait ack", 64'(d_ack), 64'd0);
         check("to err", 64'(err), 64'd0);
         step();
      end
      check("to rdata kept", 64'(d_rdata), 64'hA5A50001);
      d_req = 1'b0;
`endif
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();

      // Reset while in RESP, then a stray response.
      if_req = 1'b1; if_adr = 32'h500;
      step();
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      check("rst pre adr", 64'(mem_adr), 64'h500);
      reset_n = 1'b0; if_req = 1'b0;
      #1 check_idle_outputs("rst mid");
      step();
      reset_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      step();
      mem_rvalid = 1'b0;
      check("rst stray ack", 64'({if_ack, d_ack}), 64'd0);
      check("rst stray rdata", 64'(if_rdata), 64'd0);
      check("rst stray req", 64'(mem_req), 64'd0);
      step();
      check("rst idle ack", 64'({if_ack, d_ack}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the core's instruction fetch path and its load/store path. It serializes both requesters onto one shared external memory bus that uses a request/grant/response handshake with variable latency. It returns per-requester acknowledges and read data, and drives a pipeline stall while any request is outstanding. It sits between `core` (ifetch and exe memory interfaces) and the memory subsystem.

## Interface
Parameters:
- `XLEN`, 32, data/address width (from `riscv_pkg`).
- `TIMEOUT_CYCLES`, 255, response watchdog limit in cycles (used only with `MEM_ARB_TIMEOUT_EN`).

Ports:
- Clock and reset (already decided): reset `reset_n`, asynchronous, active-low; clock `clk`.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous active-low reset.
- `if_req_i` in 1: instruction fetch request.
- `if_adr_i` in XLEN: fetch address.
- `if_rdata_o` out 32: fetched instruction, valid with `if_ack_o`.
- `if_ack_o` out 1: fetch complete, 1-cycle pulse.
- `d_req_i` in 1: data request.
- `d_we_i` in 1: 1 = store, 0 = load.
- `d_adr_i` in XLEN: data address.
- `d_wdata_i` in XLEN: store data.
- `d_size_i` in 3: access size, passed through.
- `d_rdata_o` out XLEN: load data, valid with `d_ack_o`.
- `d_ack_o` out 1: data access complete, 1-cycle pulse.
- `mem_req_o` out 1: bus request.
- `mem_we_o` out 1: bus write enable.
- `mem_adr_o` out XLEN: bus address.
- `mem_wdata_o` out XLEN: bus write data.
- `mem_size_o` out 3: bus access size.
- `mem_gnt_i` in 1: bus accepted request this cycle.
- `mem_rvalid_i` in 1: response valid (read data or write done).
- `mem_rdata_i` in XLEN: response data.
- `stall_o` out 1: core pipeline hold.
- `err_o` out 1: sticky timeout error.

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE:**
  - Sample the effective requests `if_req_i & ~if_ack_o` and `d_req_i & ~d_ack_o`.
  - If either is set, latch the winner's fields into the `mem_*` registers, record the owner, and go to REQ.
  - Fixed priority: data wins over fetch. Exe is the older stage, so this prevents deadlock.
  - For a fetch, drive `mem_we_o`=0, `mem_size_o`=3'b010 and `mem_wdata_o`=0.
- **REQ:**
  - `mem_req_o`=1 with registered fields held stable.
  - On `mem_gnt_i`=1, drop `mem_req_o` and go to RESP.
- **RESP:**
  - Wait for `mem_rvalid_i`. On it, register `mem_rdata_i` into the owner's rdata output and pulse the owner's ack the next cycle, then go to IDLE.
  - A store also waits for `mem_rvalid_i`; `d_rdata_o` is don't-care for stores.
- Requesters hold req and all fields stable until their ack.
  - A req seen in the same cycle as its own ack is ignored; this prevents duplicate issue.
  - A new transaction may be requested from the cycle after the ack.
- `if_rdata_o` = `mem_rdata_i[31:0]`. No sign or zero extension is done here; exe performs it.
- `stall_o` = `(if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o)`, combinational.
- `mem_rvalid_i` and `mem_gnt_i` are ignored outside RESP and REQ respectively.
- When both requests are pending, fetch is served after the data access completes, on the next IDLE cycle.

## Timing
- Reset values: all outputs 0 (`mem_*`, both acks, both rdata, `err_o`); FSM in IDLE.
- Minimum latency (single request):
  - t0: req seen in IDLE.
  - t1: `mem_req_o`=1; `gnt` arrives in t1.
  - t2: in RESP; `rvalid` arrives in t2.
  - t3: ack with data.
- Each extra grant wait cycle and each extra response wait cycle adds 1 cycle.
- Back-to-back throughput: one transaction per 4 cycles minimum (IDLE, REQ, RESP, then ack in IDLE).
- Reset mid-operation: FSM returns to IDLE immediately and outputs clear. A later stray `mem_rvalid_i` is ignored.

## Configuration
- Macro: `MEM_ARB_TIMEOUT_EN`.
- Defined:
  - An 8+ bit cycle counter clears on leaving IDLE and increments in REQ and RESP.
  - When it reaches `TIMEOUT_CYCLES`, the FSM forces completion: owner's ack pulses with rdata=0, `mem_req_o` drops, and the FSM goes to IDLE.
  - `err_o` sets and stays 1 until reset.
- Undefined: no counter; the arbiter waits indefinitely; `err_o` is tied to 0.

## Test plan
- Single load: `d_req_i`=1, `d_adr_i`=0x100, gnt at t1, rvalid at t2 with 0xDEADBEEF -> `d_ack_o` and `d_rdata_o`=0xDEADBEEF at t3, `mem_we_o`=0 throughout.
- Simultaneous request: `if_req_i` and `d_req_i` at t0, store of 0x55 to 0x200 -> store issued first (`mem_we_o`=1, `mem_wdata_o`=0x55). The fetch is issued at the IDLE cycle after `d_ack_o`; `stall_o`=1 until `if_ack_o`.
- Grant stall: `mem_gnt_i` held 0 for 5 cycles -> `mem_req_o` and fields stable for 6 cycles; ack 2 cycles after gnt with zero-wait rvalid.
- Held req across ack: `if_req_i` kept 1 continuously -> exactly one bus request per ack, no duplicate issue on the ack cycle.
- Reset mid-RESP: assert `reset_n`=0 while in RESP -> all outputs 0, a subsequent `mem_rvalid_i` produces no ack.
- Timeout (with `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): no `mem_rvalid_i` -> ack with rdata 0 after 16 cycles, `err_o`=1 sticky; without the macro, no ack and `err_o`=0.
